// File: rtl/vtg_pkg.sv
// Shared timing constants, derived totals and the timing struct for video_timing_gen.
package vtg_pkg;

    // 720p60 defaults
    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BP     = 220;
    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FP     = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 20;
    localparam int DEF_PIPE_LAT = 4;

    // Syncs are carried as "asserted" flags; polarity is applied only at the output pins.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vtg_timing_t;

    localparam vtg_timing_t VTG_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0};

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vtg_delay_line.sv
// N-stage register shift line with a synchronous reset value; N = 0 is a pass-through.
module vtg_delay_line #(
    parameter int           N       = 4,
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst};
            assign q = d;
        end else begin : g_pipe
            logic [N-1:0][W-1:0] stg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    stg <= {N{RST_VAL}};
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < N; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            assign q = stg[N-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing for the HDMI output stage with pixel requests issued PIPE_LAT cycles ahead of o_de.
// Define VTG_TEST_PATTERN_EN to add an 8-bar colour test pattern (o_tp_r/g/b) aligned with o_de.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b1,
    parameter logic V_POL    = 1'b1,
    parameter int   PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                        i_pix_clk,
    input  logic                        i_rst,
    output logic                        o_req,
    output logic [$clog2(H_ACTIVE)-1:0] o_x,
    output logic [$clog2(V_ACTIVE)-1:0] o_y,
    output logic                        o_frame_start,
    output logic                        o_de,
`ifdef VTG_TEST_PATTERN_EN
    output logic [7:0]                  o_tp_r,
    output logic [7:0]                  o_tp_g,
    output logic [7:0]                  o_tp_b,
`endif
    output logic [1:0]                  o_ctrl_ch0,
    output logic [1:0]                  o_ctrl_ch1,
    output logic [1:0]                  o_ctrl_ch2
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);

    // Region bounds kept 32-bit so an end bound equal to a power-of-two total cannot wrap.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic [31:0]    h_ext;
    logic [31:0]    v_ext;
    logic           h_last;
    logic           v_last;
    vtg_timing_t    t0_d;
    vtg_timing_t    t0_q;
    vtg_timing_t    t_out;

    assign h_ext  = 32'(h_cnt);
    assign v_ext  = 32'(v_cnt);
    assign h_last = (h_cnt == HCW'(H_TOTAL - 1));
    assign v_last = (v_cnt == VCW'(V_TOTAL - 1));

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VCW'(1);
        end else begin
            h_cnt <= h_cnt + HCW'(1);
        end
    end

    // v_cnt only moves on the h wrap, so vs naturally changes only at h_cnt = 0.
    always_comb begin
        t0_d    = VTG_IDLE;
        t0_d.de = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        t0_d.hs = (h_ext >= HS_START) && (h_ext < HS_END);
        t0_d.vs = (v_ext >= VS_START) && (v_ext < VS_END);
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            t0_q          <= VTG_IDLE;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
        end else begin
            t0_q          <= t0_d;
            o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (t0_d.de) begin
                o_x <= h_cnt[XW-1:0];
                o_y <= v_cnt[YW-1:0];
            end
        end
    end

    assign o_req = t0_q.de;

    vtg_delay_line #(
        .N       (PIPE_LAT),
        .W       ($bits(vtg_timing_t)),
        .RST_VAL (VTG_IDLE)
    ) u_timing_dl (
        .clk (i_pix_clk),
        .rst (i_rst),
        .d   (t0_q),
        .q   (t_out)
    );

    assign o_de       = t_out.de;
    assign o_ctrl_ch0 = {t_out.vs ? V_POL : ~V_POL, t_out.hs ? H_POL : ~H_POL};
    assign o_ctrl_ch1 = 2'b00;
    assign o_ctrl_ch2 = 2'b00;

`ifdef VTG_TEST_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [31:0] bar;
    logic [2:0]  bar_k;
    logic [23:0] tp_d;
    logic [23:0] tp_q;
    logic [23:0] tp_out;

    // Gating with act at stage 0 makes the delayed pattern zero exactly when o_de is low.
    assign bar   = h_ext / 32'(BAR_W);
    assign bar_k = (bar > 32'd7) ? 3'd7 : bar[2:0];
    assign tp_d  = t0_d.de ? {{8{bar_k[2]}}, {8{bar_k[1]}}, {8{bar_k[0]}}} : 24'h0;

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            tp_q <= 24'h0;
        end else begin
            tp_q <= tp_d;
        end
    end

    vtg_delay_line #(
        .N       (PIPE_LAT),
        .W       (24),
        .RST_VAL (24'h0)
    ) u_tp_dl (
        .clk (i_pix_clk),
        .rst (i_rst),
        .d   (tp_q),
        .q   (tp_out)
    );

    assign {o_tp_r, o_tp_g, o_tp_b} = tp_out;
`endif

endmodule
